vga_pos_fetch: RTL

//  Reader end of the CPU-to-display sprite-position mailbox. The CPU writes six 16-bit

---
 rtl/vga_pos_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_pos_fetch.sv
// Once per frame, at the synchronized falling edge of v_sync, reads six sprite positions
// from the CPU mailbox and commits them to the renderer as one atomic set.
module vga_pos_fetch #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned MX     = 6000,
  parameter int unsigned MY     = 6004,
  parameter int unsigned P1X    = 6008,
  parameter int unsigned P1Y    = 6012,
  parameter int unsigned P2X    = 6016,
  parameter int unsigned P2Y    = 6020
) (
  input  logic              clk_50MHz,
  input  logic              clear,
  input  logic              v_sync,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] mx,
  output logic [DATA_W-1:0] my,
  output logic [DATA_W-1:0] p1x,
  output logic [DATA_W-1:0] p1y,
  output logic [DATA_W-1:0] p2x,
  output logic [DATA_W-1:0] p2y,
  output logic              frame_valid,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_COMMIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_vs_meta;
  logic                r_vs_sync;
  logic                r_vs_prev;
  logic                w_trig;
  logic [2:0]          r_idx;
  logic [2:0]          r_cnt;
  logic                w_last;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   r_shadow [6];

  // Sync flops idle high so leaving reset never looks like a v_sync fall.
  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      r_vs_meta <= 1'b1;
      r_vs_sync <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_vs_meta <= v_sync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  assign w_trig = r_vs_prev & ~r_vs_sync;
  assign w_last = (r_cnt == 3'd1);
  assign busy   = (r_state != S_IDLE);

  always_comb begin
    w_addr = ADDR_W'(MX);
    case (r_idx)
      3'd1:    w_addr = ADDR_W'(MY);
      3'd2:    w_addr = ADDR_W'(P1X);
      3'd3:    w_addr = ADDR_W'(P1Y);
      3'd4:    w_addr = ADDR_W'(P2X);
      3'd5:    w_addr = ADDR_W'(P2Y);
      default: w_addr = ADDR_W'(MX);
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    mem_req  = 1'b0;
    mem_addr = '0;
    case (r_state)
      S_IDLE: if (w_trig) w_next = S_REQ;
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = w_addr;
        if (mem_gnt) w_next = S_WAIT;
      end
      S_WAIT:   if (w_last) w_next = (r_idx == 3'd5) ? S_COMMIT : S_REQ;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      overrun     <= 1'b0;
      frame_valid <= 1'b0;
      mx  <= '0;
      my  <= '0;
      p1x <= '0;
      p1y <= '0;
      p2x <= '0;
      p2y <= '0;
      for (int unsigned i = 0; i < 6; i++) r_shadow[i] <= '0;
    end else begin
      // A trigger while a fetch (including its commit cycle) is running is dropped.
      if (w_trig && r_state != S_IDLE) overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (w_trig) r_idx <= '0;
        S_REQ:  if (mem_gnt) r_cnt <= 3'(RD_LAT);
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (w_last) begin
            r_shadow[r_idx] <= mem_rd_data;
            if (r_idx != 3'd5) r_idx <= r_idx + 3'd1;
          end
        end
        S_COMMIT: begin
          mx  <= r_shadow[0];
          my  <= r_shadow[1];
          p1x <= r_shadow[2];
          p1y <= r_shadow[3];
          p2x <= r_shadow[4];
          p2y <= r_shadow[5];
          frame_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
